// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, a one-entry buffer
// holds long-latency results, and a starvation counter forces the buffer through.
module rf_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        wb_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pend_valid,
  output logic [4:0]  pend_waddr,
  output logic [31:0] pend_wdata
);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t      state, state_n;
  logic [4:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic [3:0]  wait_cnt, wait_cnt_n;
  logic        capture;
  logic        wb_req;

  // Moore outputs, decoded from state only
  assign wb_hold    = (state == FORCE);
  assign lu_ready   = (state == IDLE);
  assign pend_valid = (state == PEND) || (state == FORCE);
  assign pend_waddr = buf_waddr;
  assign pend_wdata = buf_wdata;

  assign wb_req = wb_valid & wb_we & ~wb_hold;

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    capture    = 1'b0;
    rf_we      = wb_req;
    rf_waddr   = wb_waddr;
    rf_wdata   = wb_wdata;
    unique case (state)
      IDLE: begin
        if (lu_valid && (lu_waddr != '0)) begin
          capture    = 1'b1;
          wait_cnt_n = '0;
          state_n    = PEND;
        end
      end
      PEND: begin
        if (!wb_req) begin
          rf_we    = (buf_waddr != '0);
          rf_waddr = buf_waddr;
          rf_wdata = buf_wdata;
          state_n  = IDLE;
        end else if (wb_waddr == buf_waddr) begin
          // younger WB write to the same register supersedes the buffer
          state_n = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
          if (wait_cnt_n == 4'(STARVE_LIMIT)) state_n = FORCE;
        end
      end
      FORCE: begin
        rf_we    = (buf_waddr != '0);
        rf_waddr = buf_waddr;
        rf_wdata = buf_wdata;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (capture) begin
        buf_waddr <= lu_waddr;
        buf_wdata <= lu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a behavioural model of the pending-write buffer.
module tb_rf_wport_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_hold;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_waddr = '0;
  logic [31:0] lu_wdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_waddr;
  logic [31:0] pend_wdata;

  rf_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_hold(wb_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_waddr(pend_waddr), .pend_wdata(pend_wdata)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: a pending entry, how many cycles it has lost to WB, and whether
  // the next cycle must force it out.
  bit          m_pend = 0;
  bit          m_force = 0;
  int          m_lost = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit rst, input bit wv, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input bit lv, input logic [4:0] la,
                      input logic [31:0] ld);
    bit          req;
    bit          e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    @(posedge clk); #1;
    reset = rst; wb_valid = wv; wb_we = we; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    @(negedge clk);
    req = wv && we && !m_force;
    if (m_force || (m_pend && !req)) begin
      e_we = (m_addr != 0); e_a = m_addr; e_d = m_data;
    end else begin
      e_we = req; e_a = wa; e_d = wd;
    end
    if (!rst) begin
      chk("wb_hold", wb_hold, m_force);
      chk("lu_ready", lu_ready, !m_pend);
      chk("pend_valid", pend_valid, m_pend);
      chk("pend_waddr", pend_waddr, m_addr);
      chk("pend_wdata", pend_wdata, m_data);
      chk("rf_we", rf_we, e_we);
      if (e_we) begin
        chk("rf_waddr", rf_waddr, e_a);
        chk("rf_wdata", rf_wdata, e_d);
      end
    end
    if (rst) begin
      m_pend = 0; m_force = 0; m_lost = 0; m_addr = '0; m_data = '0;
    end else if (m_force) begin
      m_pend = 0; m_force = 0;
    end else if (m_pend) begin
      if (!req || wa == m_addr) m_pend = 0;
      else begin
        m_lost++;
        if (m_lost == LIMIT) m_force = 1;
      end
    end else if (lv && la != 0) begin
      m_pend = 1; m_lost = 0; m_addr = la; m_data = ld;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("reset_lu_ready", lu_ready, 1);
    chk("reset_pend_valid", pend_valid, 0);
    chk("reset_wb_hold", wb_hold, 0);

    // WB only
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 5'd5, 32'h1234, 0, 0, 0);
      chk("wbonly_we", rf_we, 1);
      chk("wbonly_addr", rf_waddr, 5);
      chk("wbonly_data", rf_wdata, 32'h1234);
      chk("wbonly_hold", wb_hold, 0);
    end

    // Idle port: accepted in N, written in N+1
    step(0, 0, 0, 0, 0, 1, 5'd7, 32'hDEAD);
    chk("idle_ready", lu_ready, 1);
    idle();
    chk("idle_pend", pend_valid, 1);
    chk("idle_we", rf_we, 1);
    chk("idle_addr", rf_waddr, 7);
    chk("idle_data", rf_wdata, 32'hDEAD);
    idle();
    chk("idle_back", lu_ready, 1);

    // Starvation
    step(0, 0, 0, 0, 0, 1, 5'd3, 32'hA5A5);
    for (int i = 0; i < LIMIT; i++) begin
      step(0, 1, 1, 5'd9, 32'h99, 0, 0, 0);
      chk("starve_wb_addr", rf_waddr, 9);
      chk("starve_no_hold", wb_hold, 0);
    end
    step(0, 1, 1, 5'd9, 32'h99, 0, 0, 0);
    chk("force_hold", wb_hold, 1);
    chk("force_addr", rf_waddr, 3);
    chk("force_data", rf_wdata, 32'hA5A5);
    step(0, 1, 1, 5'd9, 32'h99, 0, 0, 0);
    chk("after_force_we", rf_we, 1);
    chk("after_force_addr", rf_waddr, 9);
    chk("after_force_hold", wb_hold, 0);
    idle();

    // Same-address kill
    step(0, 0, 0, 0, 0, 1, 5'd4, 32'h4444);
    step(0, 1, 1, 5'd4, 32'h55, 0, 0, 0);
    chk("kill_data", rf_wdata, 32'h55);
    idle();
    chk("kill_pend", pend_valid, 0);
    chk("kill_no_write", rf_we, 0);

    // r0 from long-latency unit
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'h1111);
    chk("r0_ready", lu_ready, 1);
    idle();
    chk("r0_pend", pend_valid, 0);
    chk("r0_no_write", rf_we, 0);

    // Reset in PEND; WB keeps the port so the buffer is not written this cycle
    step(0, 0, 0, 0, 0, 1, 5'd6, 32'h77);
    step(1, 1, 1, 5'd1, 32'h10, 0, 0, 0);
    chk("rst_pend_waddr", rf_waddr, 1);
    idle();
    chk("rst_pend_valid", pend_valid, 0);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_no_write", rf_we, 0);

    // Random traffic, small address range to hit same-address kills
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
